// File: rtl/triangle_assemble_pkg.sv
// Shared types for the triangle assembler: f16 points, triangles, bounding boxes,
// the vertex-slot state and the f16 order key used by the optional bbox logic.
package triangle_assemble_pkg;

    typedef logic [15:0] f16_t;

    // [0] = x, [1] = y
    typedef f16_t [1:0] vec2_f16;

    // [0..2] = vertices in arrival order
    typedef vec2_f16 [2:0] tri_f16;

    typedef struct packed {
        vec2_f16 hi;
        vec2_f16 lo;
    } bbox_f16;

    typedef enum logic [1:0] {
        VTX0 = 2'd0,
        VTX1 = 2'd1,
        VTX2 = 2'd2
    } vslot_e;

    // Maps f16 bit patterns onto an unsigned total order: negatives are inverted,
    // positives get the top bit set, so -0 lands just below +0.
    function automatic f16_t f16_key(input f16_t bits);
        return bits[15] ? ~bits : (bits | 16'h8000);
    endfunction

endpackage

// File: rtl/triangle_assemble_if.sv
// Point-input and triangle-output handshake bundle of the triangle assembler.
interface triangle_assemble_if;
    import triangle_assemble_pkg::*;

    vec2_f16 screen_pt;
    logic    screen_pt_valid;
    logic    in_ready;
    tri_f16  tri_out;
    logic    tri_valid;
    logic    tri_ready;
    vec2_f16 bbox_min;
    vec2_f16 bbox_max;

    modport master (
        output screen_pt, screen_pt_valid, tri_ready,
        input  in_ready, tri_out, tri_valid, bbox_min, bbox_max
    );

    modport slave (
        input  screen_pt, screen_pt_valid, tri_ready,
        output in_ready, tri_out, tri_valid, bbox_min, bbox_max
    );

endinterface

// File: rtl/triangle_assemble_tri_fifo.sv
// First-word fall-through FIFO; a push into a full FIFO is taken only alongside a pop.
module tri_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   fill_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_LVL = DEPTH[AW:0];
    localparam logic [AW:0]   FILL_ONE = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      fill_q, fill_d;
    logic             do_push, do_pop;

    assign empty_o = (fill_q == '0);
    assign full_o  = (fill_q == FULL_LVL);
    assign fill_o  = fill_q;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   fill_d = fill_q + FILL_ONE;
            2'b01:   fill_d = fill_q - FILL_ONE;
            default: fill_d = fill_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // NOTE: storage is not reset; the fill level gates every read, so stale words are never visible.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/triangle_assemble.sv
// Groups projected points into triangles and buffers them for the rasterizer.
// Define TRI_BBOX_EN to store and present a per-triangle bounding box.
module triangle_assemble
    import triangle_assemble_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DROP_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    triangle_assemble_if.slave   bus,
    output logic [DROP_W-1:0]    drop_count
);

    localparam int FILL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [FILL_W-1:0] FULL_LVL = FIFO_DEPTH[FILL_W-1:0];
    localparam logic [DROP_W-1:0] DROP_ONE = 1;

`ifdef TRI_BBOX_EN
    typedef struct packed {
        bbox_f16 bbox;
        tri_f16  verts;
    } entry_t;

    // Ties keep the earlier vertex because only strict key comparisons replace the running value.
    function automatic bbox_f16 tri_bbox(input tri_f16 t);
        bbox_f16 b;
        b.lo = t[0];
        b.hi = t[0];
        for (int v = 1; v < 3; v++) begin
            for (int a = 0; a < 2; a++) begin
                if (f16_key(t[v][a]) < f16_key(b.lo[a])) b.lo[a] = t[v][a];
                if (f16_key(t[v][a]) > f16_key(b.hi[a])) b.hi[a] = t[v][a];
            end
        end
        return b;
    endfunction
`else
    typedef struct packed {
        tri_f16 verts;
    } entry_t;
`endif

    vslot_e            state_q, state_d;
    vec2_f16           slot0_q, slot0_d;
    vec2_f16           slot1_q, slot1_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              push_req, pop, fifo_full, fifo_empty, push_ok, drop_evt;
    logic [FILL_W-1:0] fill;
    entry_t            wr_entry, head;

    always_comb begin
        state_d  = state_q;
        slot0_d  = slot0_q;
        slot1_d  = slot1_q;
        push_req = 1'b0;
        if (flush) begin
            state_d = VTX0;
        end else if (bus.screen_pt_valid) begin
            case (state_q)
                VTX0: begin
                    slot0_d = bus.screen_pt;
                    state_d = VTX1;
                end
                VTX1: begin
                    slot1_d = bus.screen_pt;
                    state_d = VTX2;
                end
                VTX2: begin
                    push_req = 1'b1;
                    state_d  = VTX0;
                end
                default: state_d = VTX0;
            endcase
        end
    end

    assign pop      = !fifo_empty && bus.tri_ready;
    assign push_ok  = push_req && (!fifo_full || pop);
    assign drop_evt = push_req && fifo_full && !pop;

    // Saturate rather than wrap so a long overload is never misread as a small one.
    always_comb begin
        drop_d = drop_q;
        if (drop_evt && (drop_q != '1)) drop_d = drop_q + DROP_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= VTX0;
            slot0_q <= '0;
            slot1_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        wr_entry       = '0;
        wr_entry.verts = {bus.screen_pt, slot1_q, slot0_q};
`ifdef TRI_BBOX_EN
        wr_entry.bbox  = tri_bbox({bus.screen_pt, slot1_q, slot0_q});
`endif
    end

    tri_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_ok),
        .wdata_i (wr_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .fill_o  (fill)
    );

    assign bus.in_ready  = (fill < FULL_LVL);
    assign bus.tri_valid = !fifo_empty;
    assign bus.tri_out   = head.verts;
    assign drop_count    = drop_q;

`ifdef TRI_BBOX_EN
    assign bus.bbox_min = head.bbox.lo;
    assign bus.bbox_max = head.bbox.hi;
`else
    assign bus.bbox_min = '0;
    assign bus.bbox_max = '0;
`endif

endmodule

// File: tb/tb_triangle_assemble.sv
// Directed bench for triangle_assemble: table-driven triangle/flush vectors plus
// hand-written fill, drop, coincident pop, reset and bounding-box sequences.
module tb_triangle_assemble;
    import triangle_assemble_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [15:0] drop_count;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    triangle_assemble_if bus();

    triangle_assemble #(
        .FIFO_DEPTH (4),
        .DROP_W     (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .bus        (bus),
        .drop_count (drop_count)
    );

    typedef struct {
        logic    fl;
        logic    v;
        vec2_f16 p;
        logic    rdy;
        logic    e_valid;
        tri_f16  e_tri;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs just after a falling edge; outputs are sampled at the next falling edge.
    task automatic apply(input logic fl, input logic v, input vec2_f16 p, input logic rdy);
        flush               = fl;
        bus.screen_pt_valid = v;
        bus.screen_pt       = p;
        bus.tri_ready       = rdy;
        @(negedge clk);
    endtask

    function automatic vec2_f16 pt(input logic [15:0] x, input logic [15:0] y);
        vec2_f16 r;
        r[0] = x;
        r[1] = y;
        return r;
    endfunction

    function automatic tri_f16 mk_tri(input int k);
        tri_f16 t;
        for (int v = 0; v < 3; v++)
            t[v] = pt(16'(32'h1000 + k * 16 + v), 16'(32'h2000 + k * 16 + v));
        return t;
    endfunction

    task automatic push_tri(input int k, input logic rdy_last);
        tri_f16 t;
        t = mk_tri(k);
        apply(1'b0, 1'b1, t[0], 1'b0);
        apply(1'b0, 1'b1, t[1], 1'b0);
        apply(1'b0, 1'b1, t[2], rdy_last);
    endtask

    task automatic drain_expect(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            check($sformatf("drain_head_%0d", i), 128'(bus.tri_out), 128'(mk_tri(i)));
            apply(1'b0, 1'b0, '0, 1'b1);
        end
        check("drain_empty", 128'(bus.tri_valid), 128'(1'b0));
        check("drain_in_ready", 128'(bus.in_ready), 128'(1'b1));
    endtask

    initial begin
        tri_f16  t_a, t_q, t_b0, t_b1;
        vec2_f16 e_min, e_max;

        t_a = {pt(16'h4500, 16'h4600), pt(16'h4200, 16'h4400), pt(16'h3C00, 16'h4000)};
        t_q = {pt(16'h0303, 16'h0313), pt(16'h0202, 16'h0212), pt(16'h0101, 16'h0111)};

        tbl[0]  = '{1'b0, 1'b1, t_a[0], 1'b1, 1'b0, '0};
        tbl[1]  = '{1'b0, 1'b1, t_a[1], 1'b1, 1'b0, '0};
        tbl[2]  = '{1'b0, 1'b1, t_a[2], 1'b1, 1'b1, t_a};
        tbl[3]  = '{1'b0, 1'b0, '0,     1'b1, 1'b0, '0};
        tbl[4]  = '{1'b0, 1'b1, pt(16'hAAAA, 16'hAAAB), 1'b1, 1'b0, '0};
        tbl[5]  = '{1'b0, 1'b1, pt(16'hBBBA, 16'hBBBB), 1'b1, 1'b0, '0};
        tbl[6]  = '{1'b1, 1'b0, '0,     1'b1, 1'b0, '0};
        tbl[7]  = '{1'b0, 1'b1, pt(16'hCCCA, 16'hCCCB), 1'b1, 1'b0, '0};
        tbl[8]  = '{1'b1, 1'b1, pt(16'hDDDA, 16'hDDDB), 1'b1, 1'b0, '0};
        tbl[9]  = '{1'b0, 1'b1, t_q[0], 1'b0, 1'b0, '0};
        tbl[10] = '{1'b0, 1'b1, t_q[1], 1'b0, 1'b0, '0};
        tbl[11] = '{1'b0, 1'b1, t_q[2], 1'b0, 1'b1, t_q};
        tbl[12] = '{1'b0, 1'b0, '0,     1'b1, 1'b0, '0};

        rst                 = 1'b1;
        flush               = 1'b0;
        bus.screen_pt_valid = 1'b0;
        bus.screen_pt       = '0;
        bus.tri_ready       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_tri_valid", 128'(bus.tri_valid), 128'(1'b0));
        check("rst_in_ready", 128'(bus.in_ready), 128'(1'b1));
        check("rst_tri_out", 128'(bus.tri_out), 128'(0));
        check("rst_bbox_min", 128'(bus.bbox_min), 128'(0));
        check("rst_bbox_max", 128'(bus.bbox_max), 128'(0));
        check("rst_drop", 128'(drop_count), 128'(0));
        rst = 1'b0;

        // Basic triangle with immediate accept, then flush handling.
        for (int i = 0; i < 13; i++) begin
            apply(tbl[i].fl, tbl[i].v, tbl[i].p, tbl[i].rdy);
            check($sformatf("tbl%0d_valid", i), 128'(bus.tri_valid), 128'(tbl[i].e_valid));
            check($sformatf("tbl%0d_tri", i), 128'(bus.tri_out), 128'(tbl[i].e_tri));
        end

        // Fill to depth, overflow one triangle, then drain in order.
        for (int k = 1; k <= 3; k++) push_tri(k, 1'b0);
        check("fill3_in_ready", 128'(bus.in_ready), 128'(1'b1));
        push_tri(4, 1'b0);
        check("fill4_in_ready", 128'(bus.in_ready), 128'(1'b0));
        check("fill4_head", 128'(bus.tri_out), 128'(mk_tri(1)));
        push_tri(5, 1'b0);
        check("overflow_drop", 128'(drop_count), 128'(1));
        check("overflow_valid", 128'(bus.tri_valid), 128'(1'b1));
        drain_expect(1, 4);

        // Full FIFO with the third vertex coinciding with a pop.
        for (int k = 11; k <= 14; k++) push_tri(k, 1'b0);
        push_tri(15, 1'b1);
        check("coinc_in_ready", 128'(bus.in_ready), 128'(1'b0));
        check("coinc_drop", 128'(drop_count), 128'(1));
        drain_expect(12, 15);

        // Reset with two buffered triangles and one pending vertex.
        push_tri(21, 1'b0);
        push_tri(22, 1'b0);
        apply(1'b0, 1'b1, pt(16'h7777, 16'h7778), 1'b0);
        rst = 1'b1;
        apply(1'b0, 1'b0, '0, 1'b0);
        rst = 1'b0;
        check("rst2_tri_valid", 128'(bus.tri_valid), 128'(1'b0));
        check("rst2_drop", 128'(drop_count), 128'(0));
        check("rst2_in_ready", 128'(bus.in_ready), 128'(1'b1));
        push_tri(23, 1'b0);
        check("rst2_first_valid", 128'(bus.tri_valid), 128'(1'b1));
        check("rst2_first_tri", 128'(bus.tri_out), 128'(mk_tri(23)));
        apply(1'b0, 1'b0, '0, 1'b1);

        // Bounding boxes: mixed signs, then a -0/+0 pair on both axes.
        t_b0 = {pt(16'h4200, 16'hC500), pt(16'h0000, 16'h8000), pt(16'hC000, 16'h3C00)};
        t_b1 = {pt(16'h0000, 16'h8000), pt(16'h8000, 16'h0000), pt(16'h0000, 16'h8000)};
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b1, t_b0[i], 1'b0);
`ifdef TRI_BBOX_EN
        e_min = pt(16'hC000, 16'hC500);
        e_max = pt(16'h4200, 16'h3C00);
`else
        e_min = '0;
        e_max = '0;
`endif
        check("bbox0_tri", 128'(bus.tri_out), 128'(t_b0));
        check("bbox0_min", 128'(bus.bbox_min), 128'(e_min));
        check("bbox0_max", 128'(bus.bbox_max), 128'(e_max));
        apply(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b1, t_b1[i], 1'b0);
`ifdef TRI_BBOX_EN
        e_min = pt(16'h8000, 16'h8000);
        e_max = pt(16'h0000, 16'h0000);
`endif
        check("bbox1_tri", 128'(bus.tri_out), 128'(t_b1));
        check("bbox1_min", 128'(bus.bbox_min), 128'(e_min));
        check("bbox1_max", 128'(bus.bbox_max), 128'(e_max));
        apply(1'b0, 1'b0, '0, 1'b1);
        check("final_empty", 128'(bus.tri_valid), 128'(1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
